// File: rtl/udp_tx_scheduler_pkg.sv
// Shared definitions for the UDP/IP transmit scheduler: transmitter state
// encoding, header sizes, scheduler FSM states and length helpers.
package udp_pkg;

  // Transmitter state value that means "idle / frame finished".
  localparam logic [3:0] TX_IDLE = 4'd0;

  localparam int UDP_HDR_BYTES = 8;
  localparam int IP_HDR_BYTES  = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  // UDP length field: UDP header plus n 32-bit payload words (16-bit wrap).
  function automatic logic [15:0] udp_len(input logic [15:0] n_words);
    return 16'(UDP_HDR_BYTES) + (n_words << 2);
  endfunction

  // IP total length field: IP + UDP headers plus n payload words.
  function automatic logic [15:0] ip_len(input logic [15:0] n_words);
    return 16'(UDP_HDR_BYTES + IP_HDR_BYTES) + (n_words << 2);
  endfunction

endpackage

// File: rtl/udp_tx_scheduler_if.sv
// Scheduler-facing bundle: FIFO level, transmitter handshake, lengths and
// status. master = the scheduler, slave = FIFO/transmitter/host side.
interface udp_tx_scheduler_if #(
  parameter int unsigned FIFO_AW = 11
);
  logic               enable;
  logic [FIFO_AW-1:0] fifo_usedw;
  logic [3:0]         tx_state;
  logic               rdreq;
  logic               oen;
  logic [15:0]        tx_data_length;
  logic [15:0]        tx_total_length;
  logic               busy;
  logic [15:0]        pkt_count;
  logic               err_len;
  logic               err_wdog;
  logic               err_clr;

  modport master (
    input  enable, fifo_usedw, tx_state, rdreq, err_clr,
    output oen, tx_data_length, tx_total_length, busy, pkt_count,
           err_len, err_wdog
  );

  modport slave (
    output enable, fifo_usedw, tx_state, rdreq, err_clr,
    input  oen, tx_data_length, tx_total_length, busy, pkt_count,
           err_len, err_wdog
  );
endinterface

// File: rtl/udp_tx_scheduler_sched_timer.sv
// Purpose: generic clear/count counter with terminal-count flag, saturating at TERM.
// Latency: tc is a direct decode of the count register (asserts the cycle count == TERM).
// Backpressure: none; clr dominates en, counting stops at TERM until cleared.
module sched_timer #(
  parameter int unsigned TERM = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int unsigned W      = (TERM < 1) ? 1 : $clog2(TERM + 1);
  localparam logic [W-1:0] TERM_W = W'(TERM);

  logic [W-1:0] cnt_q;

  assign tc = (cnt_q == TERM_W);

  // Count up while enabled, hold at the terminal value, restart on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !tc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/udp_tx_scheduler.sv
// Purpose: decides when a UDP frame is launched, its length, and paces frames (IFG, watchdog).
// Latency: FIFO reaching threshold in IDLE -> oen high two cycles later (decision, then START).
// Backpressure: holds oen until the transmitter leaves idle; enable only gates new launches.
module udp_tx_scheduler
  import udp_pkg::*;
#(
  parameter int unsigned PKT_WORDS    = 256,
  parameter int unsigned FIFO_AW      = 11,
  parameter int unsigned FLUSH_CYCLES = 125000,
  parameter int unsigned IFG_CYCLES   = 12,
  parameter int unsigned WDOG_CYCLES  = 4096
) (
  input  logic               e_rxc,
  input  logic               reset_n,
  udp_tx_scheduler_if.master bus
);

  localparam logic [FIFO_AW-1:0] PKT_W     = FIFO_AW'(PKT_WORDS);
  localparam int unsigned        GAP_TERM  = (IFG_CYCLES  > 0) ? IFG_CYCLES  - 1 : 0;
  localparam int unsigned        WDOG_TERM = (WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0;

  sched_state_t state_q, state_d;

  logic        launch;      // launch decision this cycle (IDLE only)
  logic        launch_q;    // decision registered; START follows next cycle
  logic        done;        // transmitter finished the frame
  logic        abort;       // watchdog expired in START/SEND
  logic        fifo_full;
  logic        fifo_some;
  logic        flush_clr;
  logic        flush_tc;
  logic        gap_tc;
  logic        wdog_run;
  logic        wdog_tc;
  logic        rd_hit;
  logic [15:0] n_d;
  logic [15:0] n_q;
  logic [15:0] rd_cnt_q;
  logic [15:0] rd_total;

  logic        oen_q;
  logic        busy_q;
  logic [15:0] data_len_q;
  logic [15:0] total_len_q;
  logic [15:0] pkt_count_q;
  logic        err_len_q;
  logic        err_wdog_q;

  assign fifo_full = (bus.fifo_usedw >= PKT_W);
  assign fifo_some = (bus.fifo_usedw != '0);
  assign n_d       = fifo_full ? 16'(PKT_WORDS) : 16'(bus.fifo_usedw);

  // Flush timer only runs while idle with a partial, non-empty FIFO.
  assign flush_clr = (state_q != IDLE) || launch_q || !fifo_some || fifo_full;
  assign wdog_run  = (state_q == START) || (state_q == SEND);

  // Read strobes count from the START exit cycle onward.
  assign rd_hit   = bus.rdreq &&
                    (((state_q == START) && (bus.tx_state != TX_IDLE)) ||
                     (state_q == SEND));
  assign rd_total = rd_cnt_q + 16'(rd_hit);

  sched_timer #(.TERM(FLUSH_CYCLES)) u_flush (
    .clk   (e_rxc),
    .rst_n (reset_n),
    .clr   (flush_clr),
    .en    (1'b1),
    .tc    (flush_tc)
  );

  sched_timer #(.TERM(GAP_TERM)) u_gap (
    .clk   (e_rxc),
    .rst_n (reset_n),
    .clr   (state_q != GAP),
    .en    (state_q == GAP),
    .tc    (gap_tc)
  );

  sched_timer #(.TERM(WDOG_TERM)) u_wdog (
    .clk   (e_rxc),
    .rst_n (reset_n),
    .clr   (!wdog_run),
    .en    (wdog_run),
    .tc    (wdog_tc)
  );

  // Scheduler state register.
  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; frame completion takes precedence over a same-cycle watchdog.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch_q) begin
          state_d = START;
        end else if (bus.enable && (fifo_full || (flush_tc && fifo_some))) begin
          launch = 1'b1;
        end
      end
      START: begin
        if (wdog_tc) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (bus.tx_state != TX_IDLE) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.tx_state == TX_IDLE) begin
          done    = 1'b1;
          state_d = GAP;
        end else if (wdog_tc) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_tc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Launch pipeline, registered strobes and the per-packet word count.
  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      launch_q <= 1'b0;
      oen_q    <= 1'b0;
      busy_q   <= 1'b0;
      n_q      <= '0;
      rd_cnt_q <= '0;
    end else begin
      launch_q <= launch;
      oen_q    <= (state_d == START);
      busy_q   <= (state_d != IDLE);
      if (launch) begin
        n_q      <= n_d;
        rd_cnt_q <= '0;
      end else if (rd_hit) begin
        rd_cnt_q <= rd_total;
      end
    end
  end

  // Frame lengths are captured only at the launch decision and held until the next one.
  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      data_len_q  <= '0;
      total_len_q <= '0;
    end else if (launch) begin
      data_len_q  <= udp_len(n_d);
      total_len_q <= ip_len(n_d);
    end
  end

  // Completed-packet counter and sticky error flags; a new error beats err_clr.
  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count_q <= '0;
      err_len_q   <= 1'b0;
      err_wdog_q  <= 1'b0;
    end else begin
      if (done) begin
        pkt_count_q <= pkt_count_q + 16'd1;
      end
      if (done && (rd_total != n_q)) begin
        err_len_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_len_q <= 1'b0;
      end
      if (abort) begin
        err_wdog_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_wdog_q <= 1'b0;
      end
    end
  end

  assign bus.oen             = oen_q;
  assign bus.busy            = busy_q;
  assign bus.tx_data_length  = data_len_q;
  assign bus.tx_total_length = total_len_q;
  assign bus.pkt_count       = pkt_count_q;
  assign bus.err_len         = err_len_q;
  assign bus.err_wdog        = err_wdog_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Bench for udp_tx_scheduler: a small transmitter model answers oen after
// three cycles and issues a programmable number of rdreq strobes; expected
// packet results are queued when stimulus is applied and popped at completion.
module tb_udp_tx_scheduler;

  logic e_rxc;
  logic reset_n;

  int checks = 0;
  int errors = 0;

  udp_tx_scheduler_if #(.FIFO_AW(11)) bus ();

  udp_tx_scheduler #(
    .PKT_WORDS    (256),
    .FIFO_AW      (11),
    .FLUSH_CYCLES (100),
    .IFG_CYCLES   (12),
    .WDOG_CYCLES  (300)
  ) dut (
    .e_rxc   (e_rxc),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] dlen;
    logic [15:0] tlen;
    logic [15:0] pcnt;
    logic        elen;
  } exp_t;

  exp_t exp_q[$];
  int   pc_exp      = 0;
  int   model_words = 0;
  bit   model_hang  = 1'b0;

  initial begin
    e_rxc = 1'b0;
    forever #5 e_rxc = ~e_rxc;
  end

  // Transmitter model: answers after three oen cycles, issues model_words strobes.
  initial begin : tx_model
    int cnt;
    int left;
    bit sending;
    cnt = 0;
    left = 0;
    sending = 1'b0;
    bus.tx_state = 4'd0;
    bus.rdreq = 1'b0;
    forever begin
      @(negedge e_rxc);
      if (!reset_n) begin
        cnt = 0;
        left = 0;
        sending = 1'b0;
        bus.tx_state = 4'd0;
        bus.rdreq = 1'b0;
      end else if (!sending) begin
        bus.rdreq = 1'b0;
        if (bus.oen) begin
          cnt++;
          if (cnt == 3 && !model_hang) begin
            sending = 1'b1;
            bus.tx_state = 4'd5;
            bus.rdreq = (model_words > 0);
            left = model_words - 1;
          end
        end else begin
          cnt = 0;
        end
      end else if (left > 0) begin
        bus.rdreq = 1'b1;
        left--;
      end else begin
        bus.rdreq = 1'b0;
        bus.tx_state = 4'd0;
        sending = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int n, input logic elen);
    exp_t e;
    pc_exp++;
    e.dlen = 16'(8 + 4 * n);
    e.tlen = 16'(28 + 4 * n);
    e.pcnt = 16'(pc_exp);
    e.elen = elen;
    exp_q.push_back(e);
  endtask

  // Follows one packet from the current cycle to the end of its gap.
  task automatic observe_pkt(input string tag, input int exp_lat, input logic [10:0] usedw_after);
    int lat;
    int oc;
    int w;
    int g;
    logic [15:0] pre_d;
    logic [15:0] pre_t;
    logic [15:0] pc0;
    exp_t e;
    pc0 = bus.pkt_count;
    lat = 0;
    pre_d = bus.tx_data_length;
    pre_t = bus.tx_total_length;
    while (!bus.oen && lat < 2000) begin
      pre_d = bus.tx_data_length;
      pre_t = bus.tx_total_length;
      @(negedge e_rxc);
      lat++;
    end
    chk({tag, "_launch"}, 32'(bus.oen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_dlen_early"}, 32'(pre_d), 32'(exp_q[0].dlen));
    chk({tag, "_tlen_early"}, 32'(pre_t), 32'(exp_q[0].tlen));
    oc = 0;
    while (bus.oen && oc < 2000) begin
      oc++;
      if (oc == 1) bus.fifo_usedw = usedw_after;
      @(negedge e_rxc);
    end
    chk({tag, "_oen_cycles"}, 32'(oc), 32'd3);
    w = 0;
    while (bus.pkt_count === pc0 && w < 3000) begin
      @(negedge e_rxc);
      w++;
    end
    e = exp_q.pop_front();
    chk({tag, "_pkt_count"}, 32'(bus.pkt_count), 32'(e.pcnt));
    chk({tag, "_dlen"}, 32'(bus.tx_data_length), 32'(e.dlen));
    chk({tag, "_tlen"}, 32'(bus.tx_total_length), 32'(e.tlen));
    chk({tag, "_err_len"}, 32'(bus.err_len), 32'(e.elen));
    chk({tag, "_err_wdog"}, 32'(bus.err_wdog), 32'd0);
    g = 0;
    while (bus.busy && g < 100) begin
      if (!bus.oen) g++;
      @(negedge e_rxc);
    end
    chk({tag, "_gap"}, 32'(g), 32'd12);
  endtask

  initial begin : stim
    int w;
    int oc;
    int seen;
    reset_n = 1'b0;
    bus.enable = 1'b0;
    bus.fifo_usedw = 11'd0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge e_rxc);
    chk("rst_oen", 32'(bus.oen), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
    chk("rst_dlen", 32'(bus.tx_data_length), 32'd0);
    chk("rst_tlen", 32'(bus.tx_total_length), 32'd0);
    chk("rst_err_len", 32'(bus.err_len), 32'd0);
    chk("rst_err_wdog", 32'(bus.err_wdog), 32'd0);
    reset_n = 1'b1;
    @(negedge e_rxc);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Full packet, FIFO stays full so the next one follows after the gap.
    bus.enable = 1'b1;
    bus.fifo_usedw = 11'd256;
    model_words = 256;
    push_exp(256, 1'b0);
    observe_pkt("full1", 2, 11'd256);

    // Back-to-back packet, one word short.
    model_words = 255;
    push_exp(256, 1'b1);
    observe_pkt("short", 2, 11'd0);

    // Partial FIFO flushed after the timeout; FIFO grows after launch.
    bus.fifo_usedw = 11'd10;
    model_words = 10;
    push_exp(10, 1'b1);
    observe_pkt("flush", 102, 11'd300);

    // FIFO above threshold: length clipped to a full packet.
    model_words = 256;
    push_exp(256, 1'b1);
    observe_pkt("clip", 2, 11'd0);

    bus.err_clr = 1'b1;
    @(negedge e_rxc);
    bus.err_clr = 1'b0;
    chk("err_len_clr", 32'(bus.err_len), 32'd0);

    // Empty FIFO never launches.
    seen = 0;
    repeat (200) begin
      @(negedge e_rxc);
      if (bus.busy || bus.oen) seen++;
    end
    chk("empty_no_launch", 32'(seen), 32'd0);

    // Transmitter never answers: watchdog abort while err_clr is held.
    model_hang = 1'b1;
    bus.fifo_usedw = 11'd256;
    w = 0;
    while (!bus.oen && w < 50) begin
      @(negedge e_rxc);
      w++;
    end
    chk("wdog_launch", 32'(bus.oen), 32'd1);
    bus.enable = 1'b0;
    bus.fifo_usedw = 11'd0;
    bus.err_clr = 1'b1;
    oc = 0;
    while (bus.oen && oc < 1000) begin
      oc++;
      @(negedge e_rxc);
    end
    chk("wdog_oen_cycles", 32'(oc), 32'd300);
    chk("wdog_err", 32'(bus.err_wdog), 32'd1);
    chk("wdog_idle", 32'(bus.busy), 32'd0);
    chk("wdog_pkt_count", 32'(bus.pkt_count), 32'd4);
    bus.err_clr = 1'b0;
    @(negedge e_rxc);
    chk("wdog_sticky", 32'(bus.err_wdog), 32'd1);
    chk("wdog_no_gap", 32'(bus.busy), 32'd0);
    bus.err_clr = 1'b1;
    @(negedge e_rxc);
    bus.err_clr = 1'b0;
    chk("wdog_clr", 32'(bus.err_wdog), 32'd0);
    model_hang = 1'b0;

    // Asynchronous reset in the middle of SEND.
    bus.enable = 1'b1;
    bus.fifo_usedw = 11'd256;
    model_words = 256;
    w = 0;
    while (!bus.oen && w < 50) begin
      @(negedge e_rxc);
      w++;
    end
    chk("rst_mid_launch", 32'(bus.oen), 32'd1);
    w = 0;
    while (bus.oen && w < 50) begin
      @(negedge e_rxc);
      w++;
    end
    repeat (20) @(negedge e_rxc);
    chk("rst_mid_busy_before", 32'(bus.busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_oen", 32'(bus.oen), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_pkt_count", 32'(bus.pkt_count), 32'd0);
    chk("rst_mid_dlen", 32'(bus.tx_data_length), 32'd0);
    @(negedge e_rxc);
    @(negedge e_rxc);
    exp_q.delete();
    pc_exp = 0;
    push_exp(256, 1'b0);
    reset_n = 1'b1;
    observe_pkt("post_rst", 2, 11'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
